// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deframes
// 11-bit frames and decodes scan-code bytes into the {toggle, pressed, ext, code} event word.
module ps2_key_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Odd parity across the eight data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Protocol replies and error codes that never produce a key event.
    function automatic logic is_silent(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
               (code == 8'hFA) || (code == 8'hFE) || (code == 8'hFF);
    endfunction

    logic              clk_meta, clk_sync, dat_meta, dat_sync;
    logic              clk_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              fe;

    state_t            state;
    logic [2:0]        bitcnt;
    logic [7:0]        shreg;
    logic              par_bit;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [7:0]        byte_p0;
    logic              vld_p0;
    logic              par_err_p0;
    logic              frm_err_p0;

    logic              ext;
    logic              brk;
    logic [2:0]        skip_cnt;

    // Stage: synchronize raw pins and debounce the device clock
    always_ff @(posedge clk_sys) begin
        fe <= 1'b0;
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_meta <= ps2_clk_i;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data_i;
            dat_sync <= dat_meta;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
                fe       <= ~clk_sync;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Stage p0: frame FSM, emits the checked byte and error strobes
    always_ff @(posedge clk_sys) begin
        vld_p0     <= 1'b0;
        par_err_p0 <= 1'b0;
        frm_err_p0 <= 1'b0;
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
            byte_p0 <= '0;
        end else begin
            if (state == ST_IDLE || fe) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fe && !dat_sync) begin
                        state  <= ST_DATA;
                        busy   <= 1'b1;
                        bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fe) begin
                        shreg  <= {dat_sync, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fe) begin
                        par_bit <= dat_sync;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fe) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        byte_p0 <= shreg;
                        // A bad parity bit takes precedence over a bad stop bit.
                        if (!parity_ok(shreg, par_bit)) begin
                            par_err_p0 <= 1'b1;
                        end else if (!dat_sync) begin
                            frm_err_p0 <= 1'b1;
                        end else begin
                            vld_p0 <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (state != ST_IDLE && !fe && tmo_cnt == TMO_LAST) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                frm_err_p0 <= 1'b1;
            end
        end
    end

    // Stage p1: prefix/pause decoding and event word update
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ps2_key    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            skip_cnt   <= '0;
        end else begin
            parity_err <= par_err_p0;
            frame_err  <= frm_err_p0;
            if (vld_p0) begin
                if (skip_cnt != 3'd0) begin
                    // Pause has no break code; it is reported once as E0 77 pressed.
                    skip_cnt <= skip_cnt - 1'b1;
                    if (skip_cnt == 3'd1) begin
                        ps2_key <= {~ps2_key[10], 1'b1, 1'b1, 8'h77};
                    end
                end else if (byte_p0 == 8'hE0) begin
                    ext <= 1'b1;
                end else if (byte_p0 == 8'hF0) begin
                    brk <= 1'b1;
                end else if (byte_p0 == 8'hE1) begin
                    skip_cnt <= 3'd7;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end else if (is_silent(byte_p0)) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    ps2_key <= {~ps2_key[10], ~brk, ext, byte_p0};
                    ext     <= 1'b0;
                    brk     <= 1'b0;
                end
            end else if (par_err_p0 || frm_err_p0) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames bit by bit and checks the
// event word, error pulses and busy against hand-computed values.
module tb_ps2_key_rx;

    localparam int HALF = 80;
    localparam int TMO  = 4000;

    logic        clk_sys    = 1'b0;
    logic        reset      = 1'b1;
    logic        ps2_clk_i  = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [10:0] ps2_key;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    ps2_key_rx #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk_i (ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .ps2_key   (ps2_key),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    int          cyc           = 0;
    int          key_evts      = 0;
    int          key_cyc       = 0;
    int          perr_pulses   = 0;
    int          perr_hi       = 0;
    int          perr_cyc      = 0;
    int          ferr_pulses   = 0;
    int          ferr_hi       = 0;
    int          ferr_cyc      = 0;
    int          busy_fall_cyc = 0;
    int          busy_rises    = 0;
    int          last_fall_cyc = 0;
    logic [10:0] key_prev      = '0;
    bit          perr_prev     = 1'b0;
    bit          ferr_prev     = 1'b0;
    bit          busy_prev     = 1'b0;

    always @(negedge clk_sys) begin
        cyc++;
        if (!reset && ps2_key !== key_prev) begin
            key_evts++;
            key_cyc = cyc;
        end
        key_prev = ps2_key;
        if (parity_err === 1'b1) begin
            perr_hi++;
            if (!perr_prev) begin
                perr_pulses++;
                perr_cyc = cyc;
            end
        end
        perr_prev = (parity_err === 1'b1);
        if (frame_err === 1'b1) begin
            ferr_hi++;
            if (!ferr_prev) begin
                ferr_pulses++;
                ferr_cyc = cyc;
            end
        end
        ferr_prev = (frame_err === 1'b1);
        if (busy_prev && busy === 1'b0) busy_fall_cyc = cyc;
        if (!busy_prev && busy === 1'b1) busy_rises++;
        busy_prev = (busy === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = fr[i];
            wait_cyc(HALF);
            ps2_clk_i     = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk_i = 1'b1;
        end
        wait_cyc(HALF);
        ps2_data_i = 1'b1;
        wait_cyc(HALF);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          e0, p0, ph0, f0, fh0, b0, dt;
        logic [7:0]  pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        reset = 1'b1;
        wait_cyc(5);
        chk("rst_key",  32'(ps2_key),    32'h000);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err),  32'h0);
        chk("rst_busy", 32'(busy),       32'h0);
        reset = 1'b0;
        wait_cyc(20);

        // Make code 0x1C
        e0 = key_evts; p0 = perr_pulses; f0 = ferr_pulses;
        send_frame(8'h1C, 1'b0, 11);
        chk("t1_key",  32'(ps2_key), 32'h61C);
        chk("t1_evts", key_evts - e0, 1);
        chk("t1_lat",  key_cyc - busy_fall_cyc, 1);
        chk("t1_perr", perr_pulses - p0, 0);
        chk("t1_ferr", ferr_pulses - f0, 0);
        chk("t1_busy", 32'(busy), 32'h0);

        // Extended break: E0 F0 75
        e0 = key_evts;
        send_frame(8'hE0, 1'b0, 11);
        chk("t2_e0_noevt", key_evts - e0, 0);
        send_frame(8'hF0, 1'b0, 11);
        chk("t2_f0_noevt", key_evts - e0, 0);
        send_frame(8'h75, 1'b0, 11);
        chk("t2_key",  32'(ps2_key), 32'h175);
        chk("t2_evts", key_evts - e0, 1);

        // Bad parity frame is dropped
        e0 = key_evts; p0 = perr_pulses; ph0 = perr_hi;
        send_frame(8'h16, 1'b1, 11);
        chk("t3_perr_pulses", perr_pulses - p0, 1);
        chk("t3_perr_width",  perr_hi - ph0, 1);
        chk("t3_perr_lat",    perr_cyc - busy_fall_cyc, 1);
        chk("t3_key_hold",    32'(ps2_key), 32'h175);
        chk("t3_noevt",       key_evts - e0, 0);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h16, 1'b0, 11);
        chk("t3_key", 32'(ps2_key), 32'h416);

        // Partial frame aborted by timeout
        f0 = ferr_pulses; fh0 = ferr_hi;
        send_frame(8'h14, 1'b0, 5);
        chk("t4_busy_mid", 32'(busy), 32'h1);
        wait_cyc(TMO + 100);
        dt = ferr_cyc - last_fall_cyc;
        chk("t4_ferr_pulses", ferr_pulses - f0, 1);
        chk("t4_ferr_width",  ferr_hi - fh0, 1);
        chk("t4_tmo_window",  32'((dt >= TMO + 6) && (dt <= TMO + 18)), 32'h1);
        chk("t4_busy_after",  32'(busy), 32'h0);
        chk("t4_key_hold",    32'(ps2_key), 32'h416);
        send_frame(8'h14, 1'b0, 11);
        chk("t4_key", 32'(ps2_key), 32'h214);

        // Short clock glitch while idle (data held low so a false edge would start a frame)
        b0 = busy_rises;
        ps2_data_i = 1'b0;
        ps2_clk_i  = 1'b0;
        wait_cyc(3);
        ps2_clk_i = 1'b1;
        wait_cyc(2);
        ps2_data_i = 1'b1;
        wait_cyc(40);
        chk("t5_glitch_busy", busy_rises - b0, 0);
        e0 = key_evts;
        send_frame(8'hFA, 1'b0, 11);
        chk("t5_fa_noevt", key_evts - e0, 0);
        chk("t5_fa_key",   32'(ps2_key), 32'h214);
        e0 = key_evts;
        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0, 11);
        chk("t5_pause_evts", key_evts - e0, 1);
        chk("t5_pause_key",  32'(ps2_key), 32'h777);

        // Reset after a break prefix
        send_frame(8'hF0, 1'b0, 11);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(2);
        chk("t6_rst_key",  32'(ps2_key), 32'h000);
        chk("t6_rst_busy", 32'(busy),    32'h0);
        send_frame(8'h6B, 1'b0, 11);
        chk("t6_key", 32'(ps2_key), 32'h66B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
